// File: rtl/trace_loader.sv
// trace_loader: Wishbone slave that fills the trace SRAM and then
// hands the SRAM port over to the cache-simulator core.
module trace_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              sram_csb,
    output logic              sram_web,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout,
    output logic              sram_own,
    output logic              trace_ready,
    output logic [ADDR_W:0]   trace_len
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {IDLE, WR, RD, RDW, ACK} state_t;

    state_t             state_q, state_d;
    logic               csb_q, csb_d;
    logic               web_q, web_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  din_q, din_d;
    logic               ack_q, ack_d;
    logic [31:0]        dat_q, dat_d;
    logic               ready_q, ready_d;
    logic               own_q, own_d;
    logic [ADDR_W:0]    len_q, len_d;
    logic [ADDR_W:0]    cnt_q, cnt_d;
    logic               err_q, err_d;

    logic               req;
    logic               win;
    logic [1:0]         reg_idx;
    logic [ADDR_W-1:0]  word;
    logic               unused_bits;

    assign req     = wbs_stb_i & wbs_cyc_i & ~ack_q;
    assign win     = wbs_adr_i[10];
    assign reg_idx = wbs_adr_i[3:2];
    assign word    = wbs_adr_i[ADDR_W+1:2];
    assign unused_bits = ^{wbs_adr_i, wbs_dat_i};

    // Next-state, bus response, SRAM strobes and register updates.
    always_comb begin
        state_d = state_q;
        csb_d   = csb_q;
        web_d   = web_q;
        addr_d  = addr_q;
        din_d   = din_q;
        ack_d   = 1'b0;
        dat_d   = dat_q;
        ready_d = ready_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    ack_d   = 1'b1;
                    dat_d   = '0;
                    state_d = ACK;
                    if (win) begin
                        if (ready_q ||
                            (wbs_we_i && wbs_sel_i != 4'hF)) begin
                            err_d = 1'b1;
                        end else if (wbs_we_i) begin
                            csb_d   = 1'b0;
                            web_d   = 1'b0;
                            addr_d  = word;
                            din_d   = wbs_dat_i[DATA_W-1:0];
                            state_d = WR;
                            if (cnt_q != CNT_MAX) begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end else begin
                            ack_d   = 1'b0;
                            csb_d   = 1'b0;
                            web_d   = 1'b1;
                            addr_d  = word;
                            state_d = RD;
                        end
                    end else if (wbs_we_i) begin
                        unique case (reg_idx)
                            2'd0: begin
                                if (wbs_dat_i[1]) begin
                                    ready_d = 1'b0;
                                    cnt_d   = '0;
                                    err_d   = 1'b0;
                                end else if (wbs_dat_i[0]) begin
                                    ready_d = 1'b1;
                                end
                            end
                            2'd1: begin
                                if (wbs_dat_i > 32'(DEPTH)) begin
                                    len_d = CNT_MAX;
                                end else begin
                                    len_d = wbs_dat_i[ADDR_W:0];
                                end
                            end
                            default: ;
                        endcase
                    end else begin
                        unique case (reg_idx)
                            2'd1:    dat_d = 32'(len_q);
                            2'd2:    dat_d = {30'd0, err_q, ready_q};
                            2'd3:    dat_d = 32'(cnt_q);
                            default: dat_d = '0;
                        endcase
                    end
                end
            end
            WR: begin
                csb_d   = 1'b1;
                web_d   = 1'b1;
                state_d = ACK;
            end
            RD: begin
                csb_d   = 1'b1;
                state_d = RDW;
            end
            RDW: begin
                dat_d   = 32'(sram_dout);
                ack_d   = 1'b1;
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                csb_d   = 1'b1;
                web_d   = 1'b1;
            end
        endcase
        own_d = ~ready_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            addr_q  <= '0;
            din_q   <= '0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            ready_q <= 1'b0;
            own_q   <= 1'b1;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            csb_q   <= csb_d;
            web_q   <= web_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            ready_q <= ready_d;
            own_q   <= own_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign sram_csb    = csb_q;
    assign sram_web    = web_q;
    assign sram_addr   = addr_q;
    assign sram_din    = din_q;
    assign sram_own    = own_q;
    assign trace_ready = ready_q;
    assign trace_len   = len_q;

endmodule

// File: tb/tb_trace_loader.sv
// tb_trace_loader: directed bench for trace_loader with a
// behavioural single-port SRAM model.
module tb_trace_loader;

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        reset_n = 1'b1;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack;
    logic [31:0] rdat;
    logic        csb, web, own, ready;
    logic [7:0]  saddr;
    logic [31:0] sdin;
    logic [31:0] sdout = '0;
    logic [8:0]  tlen;

    logic [31:0] mem [256];

    int total = 0;
    int bad = 0;

    logic        s1_csb, s1_web;
    logic [7:0]  s1_addr;
    logic [31:0] s1_din;
    logic [3:1]  csb_hist;
    logic [31:0] rd;
    int          lat;

    always #5 if (clk_en) clk = ~clk;

    trace_loader dut (
        .clk(clk), .reset_n(reset_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .sram_csb(csb), .sram_web(web), .sram_addr(saddr),
        .sram_din(sdin), .sram_dout(sdout),
        .sram_own(own), .trace_ready(ready), .trace_len(tlen)
    );

    // Single-port SRAM: samples the port on the clock edge.
    always @(posedge clk) begin
        if (!csb) begin
            if (!web) mem[saddr] <= sdin;
            else      sdout <= mem[saddr];
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w;
        adr = a; wdat = d; sel = s;
        lat = 0; rd = '0; csb_hist = '1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k <= 3) csb_hist[k] = csb;
            if (k == 1) begin
                s1_csb = csb; s1_web = web;
                s1_addr = saddr; s1_din = sdin;
            end
            if (ack) begin
                lat = k;
                rd = rdat;
                break;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        if (lat == 0) check("ack_timeout", 32'd0, 32'd1);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #2 reset_n = 1'b0;
        #3;
        check("rst_csb", 32'(csb), 32'd1);
        check("rst_web", 32'(web), 32'd1);
        check("rst_addr", 32'(saddr), 32'd0);
        check("rst_din", sdin, 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", rdat, 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_own", 32'(own), 32'd1);
        check("rst_len", 32'(tlen), 32'd0);
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        repeat (2) @(posedge clk);

        xfer(1'b1, 32'h414, 32'hDEADBEEF, 4'hF);
        check("wr_lat", 32'(lat), 32'd1);
        check("wr_csb", 32'(s1_csb), 32'd0);
        check("wr_web", 32'(s1_web), 32'd0);
        check("wr_addr", 32'(s1_addr), 32'd5);
        check("wr_din", s1_din, 32'hDEADBEEF);
        xfer(1'b0, 32'hC, 32'd0, 4'hF);
        check("wcount1", rd, 32'd1);

        xfer(1'b0, 32'h414, 32'd0, 4'hF);
        check("rd_lat", 32'(lat), 32'd3);
        check("rd_data", rd, 32'hDEADBEEF);
        check("rd_csb_hist", 32'(csb_hist), 32'b110);

        xfer(1'b1, 32'h4, 32'd300, 4'hF);
        check("len_out", 32'(tlen), 32'd256);
        xfer(1'b0, 32'h4, 32'd0, 4'hF);
        check("len_rd", rd, 32'd256);
        xfer(1'b1, 32'h0, 32'd1, 4'hF);
        check("ready_set", 32'(ready), 32'd1);
        check("own_clr", 32'(own), 32'd0);
        xfer(1'b0, 32'h0, 32'd0, 4'hF);
        check("ctrl_rd0", rd, 32'd0);
        xfer(1'b1, 32'h420, 32'h11, 4'hF);
        check("blk_wr_lat", 32'(lat), 32'd1);
        check("blk_wr_csb", 32'(csb_hist), 32'b111);
        xfer(1'b0, 32'h414, 32'd0, 4'hF);
        check("blk_rd_lat", 32'(lat), 32'd1);
        check("blk_rd_dat", rd, 32'd0);
        xfer(1'b0, 32'h8, 32'd0, 4'hF);
        check("status3", rd, 32'd3);

        xfer(1'b1, 32'h0, 32'd2, 4'hF);
        check("ready_clr", 32'(ready), 32'd0);
        check("own_set", 32'(own), 32'd1);
        xfer(1'b0, 32'h8, 32'd0, 4'hF);
        check("status0", rd, 32'd0);
        xfer(1'b0, 32'hC, 32'd0, 4'hF);
        check("wcount_clr", rd, 32'd0);
        for (int i = 0; i < 260; i++) begin
            xfer(1'b1, 32'h400 | ((i % 256) << 2), 32'(i), 4'hF);
        end
        xfer(1'b0, 32'hC, 32'd0, 4'hF);
        check("wcount_sat", rd, 32'd256);
        xfer(1'b0, 32'h408, 32'd0, 4'hF);
        check("rd_word2", rd, 32'd258);
        xfer(1'b0, 32'h41C, 32'd0, 4'hF);
        check("rd_word7", rd, 32'd7);

        xfer(1'b1, 32'h424, 32'hAAAA, 4'h3);
        check("psel_lat", 32'(lat), 32'd1);
        check("psel_csb", 32'(csb_hist), 32'b111);
        xfer(1'b0, 32'h8, 32'd0, 4'hF);
        check("status_err", rd, 32'd2);
        xfer(1'b0, 32'h424, 32'd0, 4'hF);
        check("psel_keep", rd, 32'd9);

        xfer(1'b1, 32'h0, 32'd1, 4'hF);
        xfer(1'b1, 32'h0, 32'd3, 4'hF);
        xfer(1'b0, 32'h8, 32'd0, 4'hF);
        check("clr_wins", rd, 32'd0);

        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0;
        adr = 32'h414; sel = 4'hF;
        @(posedge clk); #1;
        check("mid_rd_csb", 32'(csb), 32'd0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_csb", 32'(csb), 32'd1);
        check("mid_rst_ack", 32'(ack), 32'd0);
        stb = 1'b0; cyc = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        repeat (2) @(posedge clk);
        xfer(1'b1, 32'h428, 32'h1234, 4'hF);
        check("post_wr_lat", 32'(lat), 32'd1);
        check("post_wr_csb", 32'(s1_csb), 32'd0);
        xfer(1'b0, 32'h428, 32'd0, 4'hF);
        check("post_rd_lat", 32'(lat), 32'd3);
        check("post_rd", rd, 32'h1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/trace_loader.md
Name: trace_loader

Overview:
- Wishbone slave that loads a memory-address trace into the single-port trace SRAM (32-bit x 256), then hands the SRAM over to the cache-simulator core by asserting trace_ready.
- Write-side counterpart of the trace reader inside the cache-simulator core. It replaces direct logic-analyzer driving of the SRAM port.
- Sits in user_project_wrapper between the Wishbone bus, the trace SRAM port and the simulator's trace_ready input.

Parameters:
- ADDR_W, 8, SRAM word-address width (DEPTH = 2**ADDR_W).
- DATA_W, 32, SRAM word width.

Ports:
- clk  in  1  system clock (wb_clk_i).
- reset_n  in  1  asynchronous, active-low reset.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe / cycle / write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  single-cycle acknowledge.
- wbs_dat_o  out  32  read data.
- sram_csb  out  1  SRAM chip select, active-low.
- sram_web  out  1  SRAM write enable, active-low.
- sram_addr  out  ADDR_W  SRAM word address.
- sram_din  out  DATA_W  SRAM write data.
- sram_dout  in  DATA_W  SRAM read data.
- sram_own  out  1  1 = loader owns the SRAM port; wrapper muxes the port to the simulator when 0.
- trace_ready  out  1  trace loaded; simulator may run.
- trace_len  out  ADDR_W+1  number of valid trace words.

Behaviour:
- Reset (async assert, sync deassert by flop):
  - sram_csb=1, sram_web=1, sram_addr=0, sram_din=0.
  - wbs_ack_o=0, wbs_dat_o=0.
  - trace_ready=0, sram_own=1, trace_len=0.
  - wcount=0, wr_err=0; FSM in IDLE.
- All outputs are registered. sram_own = ~trace_ready.
- Decode: wbs_adr_i[10]=1 selects the SRAM window (word = adr[ADDR_W+1:2]); wbs_adr_i[10]=0 selects registers at adr[3:2]. Upper address bits are ignored.
- Registers:
  - 0 CTRL (write-only, reads 0). Bit0 = 1 sets trace_ready. Bit1 = 1 clears trace_ready, wcount and wr_err. If both bits are set, clear wins.
  - 1 LEN (R/W). Bits [ADDR_W:0] drive trace_len. Writes above DEPTH saturate to DEPTH.
  - 2 STATUS (RO). Bit0 = trace_ready, bit1 = wr_err.
  - 3 WCOUNT (RO). Number of SRAM writes since clear, saturating at DEPTH.
- FSM states: IDLE, WR, RD, RDW, ACK.
  - IDLE: a request is accepted when stb & cyc & ~wbs_ack_o.
  - Register access: complete in IDLE; ack in cycle N+1 (N = accept cycle); go to ACK.
  - Window write, accepted when trace_ready=0 and sel=4'hF: register csb=0, web=0, addr, din → WR. In WR (cycle N+1) the SRAM samples, ack=1 and wcount++. Next: ACK, with csb=1 and web=1.
  - Window read, accepted when trace_ready=0: register csb=0, web=1 → RD (N+1). Then RDW (N+2), where csb=1 and sram_dout is captured at the end of the cycle. Ack with data in N+3 → ACK.
  - ACK: ack=0 → IDLE. Ack is always exactly one cycle. Back-to-back requests are therefore separated by at least one idle cycle.
- Blocked or invalid window accesses are acked in N+1 without touching the SRAM, reads return 0, and wr_err is set sticky. This covers:
  - any window access while trace_ready=1;
  - a window write with sel≠4'hF.
- Setting trace_ready while an SRAM op is in flight is impossible, because only one request is outstanding at a time.
- Dropping stb or cyc mid-operation does not abort the SRAM op. Ack still pulses and is ignored by the master.
- reset_n asserted mid-operation: state and outputs go immediately to reset values; an in-flight SRAM write may or may not complete.
- wcount saturates; there is no wrap.

Test Plan:
- Reset with reset_n low while clk is idle → every output at its reset value; sram_own=1; csb=1.
- Write 0xDEADBEEF to window word 5, sel=F → in cycle N+1: csb=0, web=0, sram_addr=5, sram_din=0xDEADBEEF, ack=1; WCOUNT reads 1.
- Read window word 5 with an SRAM model → ack in N+3, wbs_dat_o=0xDEADBEEF; csb is low only in N+1.
- Write LEN=300 → trace_len=256; LEN reads 256. Then write CTRL=1 → trace_ready=1, sram_own=0. A subsequent window write acks in N+1 with csb staying 1; STATUS=3.
- Write 256 words followed by 4 more (after clearing trace_ready with CTRL=2) → WCOUNT reads 256 (saturated). A partial-sel write (sel=4'h3) sets wr_err without an SRAM write.
- Assert reset_n low during RD → csb=1 and ack=0 immediately; FSM is IDLE after release; the next write completes normally.
